mac1_accum: RTL and testbench

//  First-layer neuron accumulator, directly upstream of the first-layer bias/ReLU stage.

---
 rtl/mnist_net_pkg.sv | 18 +
 rtl/mac1_accum_pix_beat_counter.sv | 28 ++
 rtl/mac1_accum.sv | 135 +++++++++++++
 tb/tb_mac1_accum.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_net_pkg.sv
// Shared MNIST network definitions: MAC1 state encoding, default widths and sum width.
package mnist_net_pkg;

    localparam int unsigned NWBITS     = 16;
    localparam int unsigned COUNT_BIT1 = 10;
    localparam int unsigned NPIX_L1    = 784;

    // Accumulator / weighted_sum width, shared with the bias stage
    localparam int unsigned SUM_W = NWBITS + COUNT_BIT1;

    typedef enum logic [1:0] {
        MAC1_IDLE     = 2'd0,
        MAC1_ACCUM    = 2'd1,
        MAC1_DONE     = 2'd2,
        MAC1_WAIT_ACK = 2'd3
    } mac1_state_e;

endpackage

// File: rtl/mac1_accum_pix_beat_counter.sv
// Beat counter for the first-layer accumulator; flags the final beat of an image.
module pix_beat_counter #(
    parameter int unsigned COUNT_BIT1 = 10,
    parameter int unsigned NPIX       = 784
) (
    input  logic clk,
    input  logic reset_b,
    input  logic clear,
    input  logic en,
    output logic last_c
);

    logic [COUNT_BIT1-1:0] cnt;

    // Clear wins over enable so a restart/abort never leaves a stale count
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + COUNT_BIT1'(1);
        end
    end

    assign last_c = (cnt == COUNT_BIT1'(NPIX - 1));

endmodule

// File: rtl/mac1_accum.sv
// First-layer neuron accumulator: sums signed weights of set pixels, hands result to bias stage.
// Optional abort input enabled by defining MAC1_ABORT_EN.
module mac1_accum
    import mnist_net_pkg::*;
#(
    parameter int unsigned NWBITS     = mnist_net_pkg::NWBITS,
    parameter int unsigned COUNT_BIT1 = mnist_net_pkg::COUNT_BIT1,
    parameter int unsigned NPIX       = mnist_net_pkg::NPIX_L1
) (
    input  logic                                 clk,
    input  logic                                 reset_b,
    input  logic                                 start,
    input  logic                                 pix_valid,
    input  logic                                 pix_bit,
    input  logic signed [NWBITS-1:0]             weight,
    output logic                                 pix_ready,
    output logic signed [NWBITS+COUNT_BIT1-1:0]  weighted_sum,
    output logic                                 add_bias,
    input  logic                                 end_state1,
`ifdef MAC1_ABORT_EN
    input  logic                                 abort,
`endif
    output logic                                 busy
);

    localparam int unsigned SW = NWBITS + COUNT_BIT1;

    if (NPIX < 1 || NPIX > (1 << COUNT_BIT1)) begin : g_bad_npix
        $error("mac1_accum: NPIX must be in 1..2**COUNT_BIT1");
    end

    mac1_state_e          state, state_nxt;
    logic signed [SW-1:0] acc, acc_nxt;
    logic signed [SW-1:0] wsum_nxt;
    logic signed [SW-1:0] term_c;
    logic                 cnt_clr, cnt_en, last_c, beat_c;
    logic                 add_bias_q;

    pix_beat_counter #(
        .COUNT_BIT1 (COUNT_BIT1),
        .NPIX       (NPIX)
    ) u_cnt (
        .clk     (clk),
        .reset_b (reset_b),
        .clear   (cnt_clr),
        .en      (cnt_en),
        .last_c  (last_c)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= MAC1_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        wsum_nxt  = weighted_sum;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        beat_c    = pix_valid && (state == MAC1_ACCUM);
        if (pix_bit) begin
            term_c = SW'(weight);
        end else begin
            term_c = '0;
        end
        case (state)
            MAC1_IDLE: begin
                if (start) begin
                    state_nxt = MAC1_ACCUM;
                    acc_nxt   = '0;
                    cnt_clr   = 1'b1;
                end
            end
            MAC1_ACCUM: begin
                if (beat_c) begin
                    cnt_en  = 1'b1;
                    acc_nxt = acc + term_c;
                    if (last_c) begin
                        wsum_nxt  = acc + term_c;
                        state_nxt = MAC1_DONE;
                    end
                end
            end
            MAC1_DONE: begin
                state_nxt = MAC1_WAIT_ACK;
            end
            MAC1_WAIT_ACK: begin
                if (end_state1) begin
                    state_nxt = MAC1_IDLE;
                end
            end
            default: begin
                state_nxt = MAC1_IDLE;
            end
        endcase
`ifdef MAC1_ABORT_EN
        // Abort overrides everything; the last completed result is kept
        if (abort && state != MAC1_IDLE) begin
            state_nxt = MAC1_IDLE;
            acc_nxt   = '0;
            wsum_nxt  = weighted_sum;
            cnt_clr   = 1'b1;
            cnt_en    = 1'b0;
        end
`endif
    end

    // Datapath and registered outputs, derived from the next state
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            acc          <= '0;
            weighted_sum <= '0;
            pix_ready    <= 1'b0;
            add_bias_q   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            acc          <= acc_nxt;
            weighted_sum <= wsum_nxt;
            pix_ready    <= (state_nxt == MAC1_ACCUM);
            add_bias_q   <= (state_nxt == MAC1_DONE);
            busy         <= (state_nxt != MAC1_IDLE);
        end
    end

`ifdef MAC1_ABORT_EN
    assign add_bias = add_bias_q && !abort;
`else
    assign add_bias = add_bias_q;
`endif

endmodule

// File: tb/tb_mac1_accum.sv
// Directed self-checking bench for mac1_accum (NPIX=4 instance plus an NPIX=784 instance).
module tb_mac1_accum;

    logic clk = 1'b0;
    logic reset_b;

    logic               start, pix_valid, pix_bit, end_state1;
    logic signed [15:0] weight;
    logic               pix_ready, add_bias, busy;
    logic signed [25:0] weighted_sum;

    logic               b_start, b_valid, b_bit, b_end;
    logic signed [15:0] b_weight;
    logic               b_ready, b_add, b_busy;
    logic signed [25:0] b_sum;

`ifdef MAC1_ABORT_EN
    logic abort;
    logic b_abort;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac1_accum #(.NWBITS(16), .COUNT_BIT1(10), .NPIX(4)) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_bit      (pix_bit),
        .weight       (weight),
        .pix_ready    (pix_ready),
        .weighted_sum (weighted_sum),
        .add_bias     (add_bias),
        .end_state1   (end_state1),
`ifdef MAC1_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy)
    );

    mac1_accum #(.NWBITS(16), .COUNT_BIT1(10), .NPIX(784)) dut_big (
        .clk          (clk),
        .reset_b      (reset_b),
        .start        (b_start),
        .pix_valid    (b_valid),
        .pix_bit      (b_bit),
        .weight       (b_weight),
        .pix_ready    (b_ready),
        .weighted_sum (b_sum),
        .add_bias     (b_add),
        .end_state1   (b_end),
`ifdef MAC1_ABORT_EN
        .abort        (b_abort),
`endif
        .busy         (b_busy)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Optional idle gap cycles, then one accepted beat on the NPIX=4 instance
    task automatic beat(input logic b, input logic signed [15:0] w, input int gap);
        for (int i = 0; i < gap; i++) begin
            pix_valid = 1'b0;
            pix_bit   = 1'b1;
            weight    = 16'sd999;
            @(negedge clk);
            chk("gap_pix_ready", 32'(pix_ready), 1);
            chk("gap_no_add_bias", 32'(add_bias), 0);
        end
        pix_valid = 1'b1;
        pix_bit   = b;
        weight    = w;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_pix_ready", 32'(pix_ready), 1);
        chk("start_busy", 32'(busy), 1);
    endtask

    task automatic ack();
        end_state1 = 1'b1;
        @(negedge clk);
        end_state1 = 1'b0;
        chk("ack_idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_b = 1'b0;
        start = 1'b0; pix_valid = 1'b0; pix_bit = 1'b0; weight = '0; end_state1 = 1'b0;
        b_start = 1'b0; b_valid = 1'b0; b_bit = 1'b0; b_weight = '0; b_end = 1'b0;
`ifdef MAC1_ABORT_EN
        abort = 1'b0; b_abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        chk("rst_pix_ready", 32'(pix_ready), 0);
        chk("rst_add_bias", 32'(add_bias), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(weighted_sum), 0);

        // 1: back-to-back beats 100,-30,(7 masked),5 -> 75
        pulse_start();
        beat(1'b1, 16'sd100, 0);
        beat(1'b1, -16'sd30, 0);
        beat(1'b0, 16'sd7, 0);
        chk("t1_pre_last_no_bias", 32'(add_bias), 0);
        beat(1'b1, 16'sd5, 0);
        chk("t1_add_bias", 32'(add_bias), 1);
        chk("t1_sum", 32'(weighted_sum), 75);
        chk("t1_done_pix_ready", 32'(pix_ready), 0);
        @(negedge clk);
        chk("t1_pulse_one_cycle", 32'(add_bias), 0);
        chk("t1_hold_sum", 32'(weighted_sum), 75);
        chk("t1_wait_busy", 32'(busy), 1);
        ack();

        // 2: same beats with two idle cycles between accepted beats
        pulse_start();
        beat(1'b1, 16'sd100, 0);
        beat(1'b1, -16'sd30, 2);
        beat(1'b0, 16'sd7, 2);
        beat(1'b1, 16'sd5, 2);
        chk("t2_add_bias", 32'(add_bias), 1);
        chk("t2_sum", 32'(weighted_sum), 75);
        @(negedge clk);
        ack();

        // 3: NPIX=784, every weight -32768 -> -25690112 without wrap
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("t3_ready", 32'(b_ready), 1);
        b_valid = 1'b1; b_bit = 1'b1; b_weight = -16'sd32768;
        repeat (783) @(negedge clk);
        chk("t3_no_early_bias", 32'(b_add), 0);
        @(negedge clk);
        b_valid = 1'b0;
        chk("t3_add_bias", 32'(b_add), 1);
        chk("t3_sum", 32'(b_sum), -25690112);
        @(negedge clk);
        chk("t3_pulse_one_cycle", 32'(b_add), 0);
        b_end = 1'b1;
        @(negedge clk);
        b_end = 1'b0;
        chk("t3_idle", 32'(b_busy), 0);

        // 4: stray start / end_state1 are ignored; start with ack is not latched
        pulse_start();
        start = 1'b1;
        beat(1'b1, 16'sd1, 0);
        start = 1'b0;
        end_state1 = 1'b1;
        beat(1'b1, 16'sd2, 0);
        end_state1 = 1'b0;
        chk("t4_still_accum", 32'(pix_ready), 1);
        beat(1'b1, 16'sd3, 0);
        beat(1'b1, 16'sd4, 0);
        chk("t4_add_bias", 32'(add_bias), 1);
        chk("t4_sum", 32'(weighted_sum), 10);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_start_in_wait_busy", 32'(busy), 1);
        chk("t4_start_in_wait_ready", 32'(pix_ready), 0);
        start = 1'b1; end_state1 = 1'b1;
        @(negedge clk);
        start = 1'b0; end_state1 = 1'b0;
        chk("t4_ack_idle", 32'(busy), 0);
        @(negedge clk);
        chk("t4_no_restart_busy", 32'(busy), 0);
        chk("t4_no_restart_ready", 32'(pix_ready), 0);
        chk("t4_sum_kept", 32'(weighted_sum), 10);

        // 5: asynchronous reset mid-image, then a clean image of 4 x 10
        pulse_start();
        beat(1'b1, 16'sd50, 0);
        beat(1'b1, 16'sd60, 0);
        #2 reset_b = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(pix_ready), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_add_bias", 32'(add_bias), 0);
        chk("t5_rst_sum", 32'(weighted_sum), 0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 4; i++) beat(1'b1, 16'sd10, 0);
        chk("t5_add_bias", 32'(add_bias), 1);
        chk("t5_sum", 32'(weighted_sum), 40);
        @(negedge clk);
        ack();

`ifdef MAC1_ABORT_EN
        // 6: abort mid-image, restart, then abort in DONE
        pulse_start();
        beat(1'b1, 16'sd500, 0);
        beat(1'b1, 16'sd600, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_abort_idle", 32'(busy), 0);
        chk("t6_abort_ready", 32'(pix_ready), 0);
        chk("t6_abort_sum_kept", 32'(weighted_sum), 40);
        @(negedge clk);
        chk("t6_abort_no_bias", 32'(add_bias), 0);
        pulse_start();
        beat(1'b1, 16'sd100, 0);
        beat(1'b1, -16'sd30, 0);
        beat(1'b0, 16'sd7, 0);
        beat(1'b1, 16'sd5, 0);
        chk("t6_restart_sum", 32'(weighted_sum), 75);
        @(negedge clk);
        ack();
        pulse_start();
        for (int i = 0; i < 4; i++) beat(1'b1, 16'sd1, 0);
        abort = 1'b1;
        #1;
        chk("t6_done_abort_no_bias", 32'(add_bias), 0);
        @(negedge clk);
        abort = 1'b0;
        chk("t6_done_abort_idle", 32'(busy), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
